// File: rtl/dog_stack.sv
// Difference-of-Gaussians stack: per channel, delays scale k by ALIGN_DELAY valid samples,
// subtracts scale k+1, scales by 2^SHIFT and clamps to the selected output range.
module dog_stack #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned NUM_DIFF    = 4,
  parameter int unsigned ALIGN_DELAY = 642,
  parameter int unsigned SHIFT       = 3,
  parameter int unsigned SIGNED_OUT  = 1
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           clear,
  input  logic [(NUM_DIFF+1)*DATA_W-1:0] g_data,
  input  logic [NUM_DIFF:0]              g_valid,
  input  logic [NUM_DIFF:0]              g_blank,
  output logic [NUM_DIFF*DATA_W-1:0]     d_data,
  output logic [NUM_DIFF-1:0]            d_valid,
  output logic [NUM_DIFF-1:0]            d_blank,
  output logic [NUM_DIFF-1:0]            sat_flag,
  output logic [NUM_DIFF-1:0]            primed
);

  localparam int unsigned PTR_W = (ALIGN_DELAY > 1) ? $clog2(ALIGN_DELAY) : 1;
  localparam int unsigned CNT_W = $clog2(ALIGN_DELAY + 1);
  localparam int unsigned SW    = DATA_W + 1 + SHIFT;

  localparam logic [SW-1:0]        ONE  = SW'(1);
  localparam logic signed [SW-1:0] SMAX = $signed((ONE << (DATA_W - 1)) - ONE);
  localparam logic signed [SW-1:0] SMIN = ~SMAX;
  localparam logic [SW-1:0]        UMAX = (ONE << DATA_W) - ONE;

  // Scale 0 only ever feeds a delay line, so its blanking flag has no consumer.
  logic unused_blank0;
  assign unused_blank0 = g_blank[0];

  for (genvar k = 0; k < NUM_DIFF; k++) begin : g_ch
    logic [DATA_W-1:0]        mem [ALIGN_DELAY];
    logic [PTR_W-1:0]         ptr_q;
    logic [CNT_W-1:0]         fill_q;
    logic                     full;
    logic                     wr_en;
    logic                     rd_en;
    logic [DATA_W-1:0]        g_wr;
    logic [DATA_W-1:0]        g_rd;
    logic [DATA_W-1:0]        tail;
    logic signed [DATA_W:0]   diff;
    logic signed [SW-1:0]     scaled;
    logic [SW-1:0]            mag;
    logic [DATA_W-1:0]        res;
    logic                     clamp;
    logic [DATA_W-1:0]        data_q;
    logic                     valid_q;
    logic                     blank_q;
    logic                     sat_q;

    assign g_wr  = g_data[k*DATA_W +: DATA_W];
    assign g_rd  = g_data[(k+1)*DATA_W +: DATA_W];
    assign wr_en = g_valid[k] & ~clear;
    assign rd_en = g_valid[k+1] & ~clear;
    assign full  = (fill_q == CNT_W'(ALIGN_DELAY));
    // Until the line has filled, stale memory (including pre-clear data) is masked to zero.
    assign tail  = full ? mem[ptr_q] : '0;

    always_comb begin
      diff   = $signed({1'b0, tail}) - $signed({1'b0, g_rd});
      scaled = SW'(diff) <<< SHIFT;
      mag    = scaled[SW-1] ? $unsigned(-scaled) : $unsigned(scaled);
      res    = '0;
      clamp  = 1'b0;
      if (SIGNED_OUT != 0) begin
        if (scaled > SMAX) begin
          res   = SMAX[DATA_W-1:0];
          clamp = 1'b1;
        end else if (scaled < SMIN) begin
          res   = SMIN[DATA_W-1:0];
          clamp = 1'b1;
        end else begin
          res = scaled[DATA_W-1:0];
        end
      end else begin
        if (mag > UMAX) begin
          res   = UMAX[DATA_W-1:0];
          clamp = 1'b1;
        end else begin
          res = mag[DATA_W-1:0];
        end
      end
    end

    always_ff @(posedge clock) begin
      if (wr_en) mem[ptr_q] <= g_wr;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        ptr_q   <= '0;
        fill_q  <= '0;
        data_q  <= '0;
        valid_q <= 1'b0;
        blank_q <= 1'b1;
        sat_q   <= 1'b0;
      end else if (clear) begin
        ptr_q   <= '0;
        fill_q  <= '0;
        valid_q <= 1'b0;
        sat_q   <= 1'b0;
      end else begin
        if (wr_en) begin
          ptr_q <= (ptr_q == PTR_W'(ALIGN_DELAY - 1)) ? '0 : ptr_q + PTR_W'(1);
          if (!full) fill_q <= fill_q + CNT_W'(1);
        end
        valid_q <= rd_en & ~g_blank[k+1] & full;
        if (rd_en) begin
          data_q  <= res;
          blank_q <= g_blank[k+1] | ~full;
          if (clamp) sat_q <= 1'b1;
        end
      end
    end

    assign d_data[k*DATA_W +: DATA_W] = data_q;
    assign d_valid[k]                 = valid_q;
    assign d_blank[k]                 = blank_q;
    assign sat_flag[k]                = sat_q;
    assign primed[k]                  = full;
  end

endmodule

// File: tb/tb_dog_stack.sv
// Directed bench for dog_stack: signed (delay 4), absolute-value (delay 4) and default-delay
// instances share one input bus; channel 0 is exercised with hand-computed expectations.
`timescale 1ns/100ps
module tb_dog_stack;
  localparam int unsigned DW = 8;
  localparam int unsigned ND = 4;

  logic                   clock   = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   clear   = 1'b0;
  logic [(ND+1)*DW-1:0]   g_data  = '0;
  logic [ND:0]            g_valid = '0;
  logic [ND:0]            g_blank = '0;

  logic [ND*DW-1:0] s_data, a_data, b_data;
  logic [ND-1:0]    s_valid, s_blank, s_sat, s_primed;
  logic [ND-1:0]    a_valid, a_blank, a_sat, a_primed;
  logic [ND-1:0]    b_valid, b_blank, b_sat, b_primed;

  int n_cmp = 0;
  int n_bad = 0;

  dog_stack #(.DATA_W(DW), .NUM_DIFF(ND), .ALIGN_DELAY(4), .SHIFT(3), .SIGNED_OUT(1)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .g_data(g_data), .g_valid(g_valid),
    .g_blank(g_blank), .d_data(s_data), .d_valid(s_valid), .d_blank(s_blank),
    .sat_flag(s_sat), .primed(s_primed)
  );

  dog_stack #(.DATA_W(DW), .NUM_DIFF(ND), .ALIGN_DELAY(4), .SHIFT(3), .SIGNED_OUT(0)) u_abs (
    .clock(clock), .reset_n(reset_n), .clear(clear), .g_data(g_data), .g_valid(g_valid),
    .g_blank(g_blank), .d_data(a_data), .d_valid(a_valid), .d_blank(a_blank),
    .sat_flag(a_sat), .primed(a_primed)
  );

  dog_stack #(.DATA_W(DW), .NUM_DIFF(ND)) u_big (
    .clock(clock), .reset_n(reset_n), .clear(clear), .g_data(g_data), .g_valid(g_valid),
    .g_blank(g_blank), .d_data(b_data), .d_valid(b_valid), .d_blank(b_blank),
    .sat_flag(b_sat), .primed(b_primed)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] g0, input logic [7:0] g1, input logic [ND:0] v,
                       input logic [ND:0] b);
    g_data  = {24'd0, g1, g0};
    g_valid = v;
    g_blank = b;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    clear   = 1'b0;
    drive(8'd0, 8'd0, '0, '0);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (s_data !== '0) begin n_bad++; $display("FAIL rst_data got %0h want 0", s_data); end
    n_cmp++; if (s_valid !== 4'h0) begin n_bad++; $display("FAIL rst_valid got %0h want 0", s_valid); end
    n_cmp++; if (s_blank !== 4'hF) begin n_bad++; $display("FAIL rst_blank got %0h want f", s_blank); end
    n_cmp++; if (s_sat !== 4'h0) begin n_bad++; $display("FAIL rst_sat got %0h want 0", s_sat); end
    n_cmp++; if (s_primed !== 4'h0) begin n_bad++; $display("FAIL rst_primed got %0h want 0", s_primed); end
    n_cmp++; if (b_primed !== 4'h0) begin n_bad++; $display("FAIL rst_big_primed got %0h want 0", b_primed); end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_ramp();
    logic ev, es, ep;
    int   ed;
    do_reset();
    for (int n = 0; n < 22; n++) begin
      drive(8'(n), 8'd0, '1, '0);
      tick();
      ev = (n >= 4);
      es = (n >= 20);
      ep = (n >= 3);
      ed = (n < 4) ? 0 : (((n - 4) * 8 > 127) ? 127 : (n - 4) * 8);
      n_cmp++; if (s_valid[0] !== ev) begin n_bad++; $display("FAIL ramp_valid n=%0d got %0b want %0b", n, s_valid[0], ev); end
      n_cmp++; if (s_data[7:0] !== 8'(ed)) begin n_bad++; $display("FAIL ramp_data n=%0d got %0d want %0d", n, s_data[7:0], ed); end
      n_cmp++; if (s_sat[0] !== es) begin n_bad++; $display("FAIL ramp_sat n=%0d got %0b want %0b", n, s_sat[0], es); end
      n_cmp++; if (s_primed[0] !== ep) begin n_bad++; $display("FAIL ramp_primed n=%0d got %0b want %0b", n, s_primed[0], ep); end
    end
  endtask

  task automatic test_abs();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(8'd10, 8'd0, 5'b00011, '0);
      tick();
    end
    drive(8'd0, 8'd30, 5'b00011, '0);
    tick();
    n_cmp++; if (a_data[7:0] !== 8'd160) begin n_bad++; $display("FAIL abs_data got %0d want 160", a_data[7:0]); end
    n_cmp++; if (a_valid[0] !== 1'b1) begin n_bad++; $display("FAIL abs_valid got %0b want 1", a_valid[0]); end
    n_cmp++; if (a_sat[0] !== 1'b0) begin n_bad++; $display("FAIL abs_sat_early got %0b want 0", a_sat[0]); end
    n_cmp++; if (s_data[7:0] !== 8'h80) begin n_bad++; $display("FAIL neg_clamp got %0h want 80", s_data[7:0]); end
    n_cmp++; if (s_sat[0] !== 1'b1) begin n_bad++; $display("FAIL neg_clamp_sat got %0b want 1", s_sat[0]); end
    for (int i = 0; i < 3; i++) begin
      drive(8'd0, 8'd30, 5'b00011, '0);
      tick();
      n_cmp++; if (a_data[7:0] !== 8'd160) begin n_bad++; $display("FAIL abs_hold i=%0d got %0d want 160", i, a_data[7:0]); end
    end
    drive(8'd0, 8'd255, 5'b00011, '0);
    tick();
    n_cmp++; if (a_data[7:0] !== 8'd255) begin n_bad++; $display("FAIL abs_clamp got %0d want 255", a_data[7:0]); end
    n_cmp++; if (a_sat[0] !== 1'b1) begin n_bad++; $display("FAIL abs_sat got %0b want 1", a_sat[0]); end
  endtask

  task automatic test_blank();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(8'd5, 8'd0, 5'b00011, '0);
      tick();
      n_cmp++; if (s_blank[0] !== 1'b1) begin n_bad++; $display("FAIL unprimed_blank i=%0d got %0b want 1", i, s_blank[0]); end
    end
    drive(8'd5, 8'd1, 5'b00011, 5'b00010);
    tick();
    n_cmp++; if (s_blank[0] !== 1'b1) begin n_bad++; $display("FAIL blank_flag got %0b want 1", s_blank[0]); end
    n_cmp++; if (s_valid[0] !== 1'b0) begin n_bad++; $display("FAIL blank_valid got %0b want 0", s_valid[0]); end
    n_cmp++; if (s_data[7:0] !== 8'd32) begin n_bad++; $display("FAIL blank_data got %0d want 32", s_data[7:0]); end
    drive(8'd5, 8'd2, 5'b00011, '0);
    tick();
    n_cmp++; if (s_valid[0] !== 1'b1) begin n_bad++; $display("FAIL unblank_valid got %0b want 1", s_valid[0]); end
    n_cmp++; if (s_blank[0] !== 1'b0) begin n_bad++; $display("FAIL unblank_flag got %0b want 0", s_blank[0]); end
    n_cmp++; if (s_data[7:0] !== 8'd24) begin n_bad++; $display("FAIL unblank_data got %0d want 24", s_data[7:0]); end
    drive(8'd5, 8'd2, '0, '0);
    tick();
    n_cmp++; if (s_valid[0] !== 1'b0) begin n_bad++; $display("FAIL pulse_len got %0b want 0", s_valid[0]); end
    n_cmp++; if (s_data[7:0] !== 8'd24) begin n_bad++; $display("FAIL data_hold got %0d want 24", s_data[7:0]); end
  endtask

  task automatic test_gap();
    logic ep, ev;
    int   ed;
    do_reset();
    for (int c = 0; c < 13; c++) begin
      drive(8'(10 + c / 2), 8'd0, {3'b000, 1'b1, (c % 2 == 0)}, '0);
      tick();
      ep = (c >= 6);
      ev = (c >= 7);
      ed = (c >= 7) ? 8 * (10 + (c - 7) / 2) : 0;
      n_cmp++; if (s_primed[0] !== ep) begin n_bad++; $display("FAIL gap_primed c=%0d got %0b want %0b", c, s_primed[0], ep); end
      n_cmp++; if (s_valid[0] !== ev) begin n_bad++; $display("FAIL gap_valid c=%0d got %0b want %0b", c, s_valid[0], ev); end
      n_cmp++; if (s_data[7:0] !== 8'(ed)) begin n_bad++; $display("FAIL gap_data c=%0d got %0d want %0d", c, s_data[7:0], ed); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int n = 0; n < 6; n++) begin
      drive(8'(n), 8'd0, '1, '0);
      tick();
    end
    drive(8'd6, 8'd255, '1, '0);
    tick();
    n_cmp++; if (s_valid[0] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_valid got %0b want 1", s_valid[0]); end
    n_cmp++; if (s_sat[0] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_sat got %0b want 1", s_sat[0]); end
    drive(8'd7, 8'd0, '1, '0);
    #2;
    reset_n = 1'b0;
    #0.5;
    n_cmp++; if (s_valid !== 4'h0) begin n_bad++; $display("FAIL arst_valid got %0h want 0", s_valid); end
    n_cmp++; if (s_blank !== 4'hF) begin n_bad++; $display("FAIL arst_blank got %0h want f", s_blank); end
    n_cmp++; if (s_data !== '0) begin n_bad++; $display("FAIL arst_data got %0h want 0", s_data); end
    n_cmp++; if (s_sat !== 4'h0) begin n_bad++; $display("FAIL arst_sat got %0h want 0", s_sat); end
    n_cmp++; if (s_primed !== 4'h0) begin n_bad++; $display("FAIL arst_primed got %0h want 0", s_primed); end
    #0.5;
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      drive(8'(n + 20), 8'd0, '1, '0);
      tick();
      n_cmp++; if (s_valid[0] !== (n >= 4)) begin n_bad++; $display("FAIL post_rst_valid n=%0d got %0b want %0b", n, s_valid[0], (n >= 4)); end
      if (n == 4) begin
        n_cmp++; if (s_data[7:0] !== 8'd127) begin n_bad++; $display("FAIL post_rst_data got %0d want 127", s_data[7:0]); end
      end
    end
  endtask

  task automatic test_clear();
    do_reset();
    for (int n = 0; n < 643; n++) begin
      drive(8'd100, 8'd0, '1, '0);
      tick();
    end
    n_cmp++; if (b_primed[0] !== 1'b1) begin n_bad++; $display("FAIL big_primed got %0b want 1", b_primed[0]); end
    n_cmp++; if (b_valid[0] !== 1'b1) begin n_bad++; $display("FAIL big_valid got %0b want 1", b_valid[0]); end
    n_cmp++; if (b_data[7:0] !== 8'd127) begin n_bad++; $display("FAIL big_data got %0d want 127", b_data[7:0]); end
    n_cmp++; if (b_sat[0] !== 1'b1) begin n_bad++; $display("FAIL big_sat got %0b want 1", b_sat[0]); end
    clear = 1'b1;
    drive(8'd100, 8'd0, '1, '0);
    tick();
    clear = 1'b0;
    n_cmp++; if (b_primed[0] !== 1'b0) begin n_bad++; $display("FAIL clr_primed got %0b want 0", b_primed[0]); end
    n_cmp++; if (b_sat[0] !== 1'b0) begin n_bad++; $display("FAIL clr_sat got %0b want 0", b_sat[0]); end
    n_cmp++; if (b_valid[0] !== 1'b0) begin n_bad++; $display("FAIL clr_valid got %0b want 0", b_valid[0]); end
    for (int n = 0; n < 643; n++) begin
      drive(8'd0, 8'd0, '1, '0);
      tick();
      if (n < 642) begin
        n_cmp++; if (b_valid[0] !== 1'b0) begin n_bad++; $display("FAIL refill_valid n=%0d got %0b data %0d want 0", n, b_valid[0], b_data[7:0]); end
      end else begin
        n_cmp++; if (b_valid[0] !== 1'b1) begin n_bad++; $display("FAIL refill_first_valid got %0b want 1", b_valid[0]); end
        n_cmp++; if (b_data[7:0] !== 8'd0) begin n_bad++; $display("FAIL refill_data got %0d want 0", b_data[7:0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_abs();
    test_blank();
    test_gap();
    test_async_reset();
    test_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
